macrocell_bank: RTL and testbench
=================================

Name: macrocell_bank

Overview:
- Parametrised array of MC_COUNT simulated CPLD macrocells. Each cell has a runtime-selectable D or T register, a combinational bypass, an XOR inverter, feedback select and a cascade chain.
- Per-cell configuration is loaded serially into a shadow chain under a loader FSM, then committed atomically.
- Sits between the product-term arrays (pre-ORed sums per cell) and the pad/feedback network.

Parameters:
MC_COUNT, 16, number of macrocells (1..64)
CFG_BITS, 6, config bits per cell (fixed layout below; must be 6)
CNT_W, 10, width of the bit counter; must satisfy 2^CNT_W > MC_COUNT*CFG_BITS

Ports:
gclk_v  input  1  clock; all state updates on rising edge
gclr_v  input  1  asynchronous active-high reset
pt_or_v  input  MC_COUNT  per-cell ORed product-term sum
ce_v  input  MC_COUNT  per-cell register clock enable
as_v  input  MC_COUNT  per-cell asynchronous set, active-high
ar_v  input  MC_COUNT  per-cell asynchronous reset, active-high
cfg_load_v  input  1  high while serial config bits are presented
cfg_di_v  input  1  serial config data
cfg_busy_v  output  1  loader in SHIFT state
cfg_err_v  output  1  one-cycle pulse on aborted load
cfg_do_v  output  1  readback data (optional feature)
pad_v  output  MC_COUNT  per-cell pad value
oe_v  output  MC_COUNT  per-cell output enable
fb_v  output  MC_COUNT  per-cell feedback to the array
cas_out_v  output  1  cascade out of the last cell

Behaviour:
- Per-cell config bits, active and shadow: [0] storage_mux (1=registered), [1] tff_mux (1=T), [2] xor_inv_mux, [3] fb_mux (1=comb), [4] casc_mux (donate sum to the next cell), [5] oe_mux.
- Chain length is TOT = MC_COUNT*6. Cell i occupies bits [6i+5:6i].
- Cascade:
  - sum_i = pt_or_v[i] | casin_i.
  - casin_0 = 0; casin_i = casc_mux[i-1] ? sum_{i-1} : 0.
  - cas_out_v = casc_mux[last] ? sum_last : 0.
  - The chain ripples combinationally.
- Cell logic:
  - x_i = (casc_mux[i] ? 0 : sum_i) ^ xor_inv_mux[i].
  - Register update when ce_v[i]=1: D mode q<=x_i; T mode q<=q^x_i. When ce_v[i]=0, q holds.
  - ar_v dominates as_v. Both are asynchronous and act independently of ce_v.
  - out_i = storage_mux ? q_i : x_i.
  - pad_v[i] = oe_mux ? out_i : 0; oe_v[i] = oe_mux.
  - fb_v[i] = fb_mux ? x_i : q_i.
- Loader FSM:
  - IDLE:
    - cfg_load_v=1 -> SHIFT. The bit presented on this same edge is captured as the first bit, and cnt=1.
  - SHIFT:
    - Each cycle with cfg_load_v=1: shadow <= {cfg_di_v, shadow[TOT-1:1]} and cnt++. The first bit shifted ends at index 0 after TOT shifts.
    - cfg_load_v=0 with cnt==TOT -> COMMIT.
    - cfg_load_v=0 with cnt!=TOT -> ABORT. This includes cnt>TOT: shifting continues past TOT, cnt saturates at all-ones, and the load is treated as an overrun.
  - COMMIT: active <= shadow for one cycle, then IDLE. cfg_load_v during COMMIT is ignored.
  - ABORT: cfg_err_v=1 for one cycle; shadow discarded and active unchanged; then IDLE.
  - cfg_busy_v=1 only in SHIFT.
- Commit changes configuration only. Register contents are preserved, and the new mode applies from the first edge after commit.
- Reset (gclr_v=1, asynchronous, any state including mid-load):
  - All q=0, active=0, shadow=0, cnt=0, FSM=IDLE, cfg_err_v=0.
  - Resulting outputs: pad_v=0, oe_v=0, cfg_busy_v=0, cfg_do_v=0.
  - fb_v = q = 0; cas_out_v = 0.
  - Shifting resumes only after release.

Optional Feature:
- Macro: MC_CFG_READBACK_EN.
- Defined:
  - In IDLE, a readback copy of active is loaded each cycle.
  - While in SHIFT, that copy shifts out LSB first on cfg_do_v, one bit per cycle in step with input shifting. Bit 0 of active appears during the first SHIFT cycle.
  - A full load therefore returns the previous configuration.
- Undefined: cfg_do_v tied to 0 and no readback register.

Test Plan:
1. Reset then idle: gclr_v pulse, pt_or_v=all ones -> pad_v=0, oe_v=0, fb_v=0, cas_out_v=0.
2. Load cell0 config 6'b100001 (registered D, oe), rest zero; drive pt_or_v[0]=1, ce_v[0]=1 -> pad_v[0]=1 one edge after commit, fb_v[0]=1.
3. T mode: cell0 config 6'b100011, pt_or_v[0]=1, ce_v[0]=1 for 4 edges -> pad_v[0] sequence 1,0,1,0. Then ce_v[0]=0 -> holds.
4. Cascade: cells 0,1 casc_mux=1; cell2 comb with oe; pt_or_v[0]=1 only -> pad_v[2]=1, pad_v[0]=0. With xor_inv on cell2 -> pad_v[2]=0.
5. Abort: drop cfg_load_v after TOT-1 bits -> cfg_err_v one-cycle pulse; active unchanged; outputs stay as before.
6. gclr_v asserted mid-SHIFT while as_v[3]=1 and ar_v[3]=1 -> q3=0, active=0, FSM idle. With MC_CFG_READBACK_EN, a new load returns all zeros on cfg_do_v.

Source files
------------

// File: rtl/macrocell_bank.sv
// Bank of MC_COUNT CPLD-style macrocells with a serially loaded, atomically committed config chain.
// Optional readback of the active configuration on cfg_do_v: define MC_CFG_READBACK_EN.
module macrocell_bank #(
  parameter int unsigned MC_COUNT = 16,
  parameter int unsigned CFG_BITS = 6,
  parameter int unsigned CNT_W    = 10
) (
  input  logic                gclk_v,
  input  logic                gclr_v,
  input  logic [MC_COUNT-1:0] pt_or_v,
  input  logic [MC_COUNT-1:0] ce_v,
  input  logic [MC_COUNT-1:0] as_v,
  input  logic [MC_COUNT-1:0] ar_v,
  input  logic                cfg_load_v,
  input  logic                cfg_di_v,
  output logic                cfg_busy_v,
  output logic                cfg_err_v,
  output logic                cfg_do_v,
  output logic [MC_COUNT-1:0] pad_v,
  output logic [MC_COUNT-1:0] oe_v,
  output logic [MC_COUNT-1:0] fb_v,
  output logic                cas_out_v
);

  localparam int unsigned TOT = MC_COUNT * CFG_BITS;

  localparam int unsigned B_STORAGE = 0;
  localparam int unsigned B_TFF     = 1;
  localparam int unsigned B_XOR     = 2;
  localparam int unsigned B_FB      = 3;
  localparam int unsigned B_CASC    = 4;
  localparam int unsigned B_OE      = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_ABORT  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TOT-1:0]      shadow_q, shadow_d;
  logic [TOT-1:0]      active_q, active_d;
  logic [MC_COUNT-1:0] q_q, q_d;
  logic [MC_COUNT-1:0] x_c;

  // Loader state registers
  always_ff @(posedge gclk_v or posedge gclr_v) begin
    if (gclr_v) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Loader next-state: overrun keeps shifting with a saturating count and ends in ABORT
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_load_v) begin
          state_d  = ST_SHIFT;
          shadow_d = {cfg_di_v, shadow_q[TOT-1:1]};
          cnt_d    = CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cfg_load_v) begin
          shadow_d = {cfg_di_v, shadow_q[TOT-1:1]};
          cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (cnt_q == CNT_W'(TOT)) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_ABORT;
        end
      end
      ST_COMMIT: begin
        active_d = shadow_q;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        shadow_d = '0;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  assign cfg_busy_v = (state_q == ST_SHIFT);
  assign cfg_err_v  = (state_q == ST_ABORT);

`ifdef MC_CFG_READBACK_EN
  logic [TOT-1:0] rb_q, rb_d;

  // Readback copy tracks active while idle and drains LSB first while shifting
  always_comb begin
    rb_d = rb_q;
    if (state_q == ST_IDLE) begin
      rb_d = active_q;
    end else if ((state_q == ST_SHIFT) && cfg_load_v) begin
      rb_d = rb_q >> 1;
    end
  end

  always_ff @(posedge gclk_v or posedge gclr_v) begin
    if (gclr_v) begin
      rb_q <= '0;
    end else begin
      rb_q <= rb_d;
    end
  end

  assign cfg_do_v = (state_q == ST_SHIFT) & rb_q[0];
`else
  assign cfg_do_v = 1'b0;
`endif

  // Cascade ripple and per-cell combinational datapath
  always_comb begin
    logic carry;
    logic sum;
    logic out;
    carry     = 1'b0;
    x_c       = '0;
    q_d       = '0;
    pad_v     = '0;
    oe_v      = '0;
    fb_v      = '0;
    for (int i = 0; i < int'(MC_COUNT); i++) begin
      sum    = pt_or_v[i] | carry;
      x_c[i] = (active_q[CFG_BITS*i + B_CASC] ? 1'b0 : sum) ^ active_q[CFG_BITS*i + B_XOR];
      carry  = active_q[CFG_BITS*i + B_CASC] ? sum : 1'b0;
      q_d[i] = active_q[CFG_BITS*i + B_TFF] ? (q_q[i] ^ x_c[i]) : x_c[i];
      out    = active_q[CFG_BITS*i + B_STORAGE] ? q_q[i] : x_c[i];
      oe_v[i]  = active_q[CFG_BITS*i + B_OE];
      pad_v[i] = active_q[CFG_BITS*i + B_OE] ? out : 1'b0;
      fb_v[i]  = active_q[CFG_BITS*i + B_FB] ? x_c[i] : q_q[i];
    end
    cas_out_v = carry;
  end

  // Per-cell register with independent async reset/set; reset wins over set
  for (genvar g = 0; g < int'(MC_COUNT); g++) begin : g_cell
    logic cell_q;

    always_ff @(posedge gclk_v or posedge gclr_v or posedge ar_v[g] or posedge as_v[g]) begin
      if (gclr_v || ar_v[g]) begin
        cell_q <= 1'b0;
      end else if (as_v[g]) begin
        cell_q <= 1'b1;
      end else if (ce_v[g]) begin
        cell_q <= q_d[g];
      end
    end

    assign q_q[g] = cell_q;
  end

endmodule

// File: tb/tb_macrocell_bank.sv
// Self-checking bench for macrocell_bank: directed scenarios plus random configs against a behavioural model.
module tb_macrocell_bank;

  localparam int unsigned MC  = 16;
  localparam int unsigned TOT = MC * 6;

  logic          gclk_v = 1'b0;
  logic          gclr_v = 1'b0;
  logic [MC-1:0] pt_or_v = '0, ce_v = '0, as_v = '0, ar_v = '0;
  logic          cfg_load_v = 1'b0, cfg_di_v = 1'b0;
  logic          cfg_busy_v, cfg_err_v, cfg_do_v, cas_out_v;
  logic [MC-1:0] pad_v, oe_v, fb_v;

  macrocell_bank #(.MC_COUNT(MC), .CFG_BITS(6), .CNT_W(10)) dut (
    .gclk_v(gclk_v), .gclr_v(gclr_v), .pt_or_v(pt_or_v), .ce_v(ce_v), .as_v(as_v), .ar_v(ar_v),
    .cfg_load_v(cfg_load_v), .cfg_di_v(cfg_di_v), .cfg_busy_v(cfg_busy_v), .cfg_err_v(cfg_err_v),
    .cfg_do_v(cfg_do_v), .pad_v(pad_v), .oe_v(oe_v), .fb_v(fb_v), .cas_out_v(cas_out_v)
  );

  always #5 gclk_v = ~gclk_v;

  int tests = 0;
  int fails = 0;

  // Model state: committed configuration and register contents per cell
  logic [5:0]    cfg_m [MC];
  logic [MC-1:0] q_m = '0;
  logic [MC-1:0] pad_e, oe_e, fb_e, x_e;
  logic          cas_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(MC); i++) cfg_m[i] = '0;
    q_m = '0;
  endtask

  task automatic eval_model(input logic [MC-1:0] pt);
    int donated;
    donated = 0;
    for (int i = 0; i < int'(MC); i++) begin
      int s;
      s = int'(pt[i]) | donated;
      x_e[i] = (cfg_m[i][4] ? 1'b0 : s[0]) ^ cfg_m[i][2];
      donated = cfg_m[i][4] ? s : 0;
      oe_e[i] = cfg_m[i][5];
      pad_e[i] = cfg_m[i][5] ? (cfg_m[i][0] ? q_m[i] : x_e[i]) : 1'b0;
      fb_e[i] = cfg_m[i][3] ? x_e[i] : q_m[i];
    end
    cas_e = donated[0];
  endtask

  task automatic check_all(input string tag);
    eval_model(pt_or_v);
    chk({tag, "_pad"}, 64'(pad_v), 64'(pad_e));
    chk({tag, "_oe"},  64'(oe_v),  64'(oe_e));
    chk({tag, "_fb"},  64'(fb_v),  64'(fb_e));
    chk({tag, "_cas"}, 64'(cas_out_v), 64'(cas_e));
  endtask

  // One clock of datapath activity; async controls are pulsed so every assertion is a fresh edge
  task automatic step(input logic [MC-1:0] pt, input logic [MC-1:0] ce,
                      input logic [MC-1:0] as_i, input logic [MC-1:0] ar_i);
    @(negedge gclk_v);
    as_v = '0; ar_v = '0;
    #1;
    pt_or_v = pt; ce_v = ce; as_v = as_i; ar_v = ar_i;
    for (int i = 0; i < int'(MC); i++) begin
      if (ar_i[i]) q_m[i] = 1'b0;
      else if (as_i[i]) q_m[i] = 1'b1;
    end
    #1;
    check_all("step");
    @(posedge gclk_v);
    for (int i = 0; i < int'(MC); i++) begin
      if (ar_i[i]) q_m[i] = 1'b0;
      else if (as_i[i]) q_m[i] = 1'b1;
      else if (ce[i]) q_m[i] = cfg_m[i][1] ? (q_m[i] ^ x_e[i]) : x_e[i];
    end
    #1;
  endtask

  // Serial load of n bits (bit 0 first); commit only when n equals the chain length
  task automatic load_cfg(input logic [TOT-1:0] bits, input int n);
    @(negedge gclk_v);
    ce_v = '0; as_v = '0; ar_v = '0;
    cfg_load_v = 1'b1; cfg_di_v = bits[0];
    for (int k = 1; k < n; k++) begin
      @(negedge gclk_v);
      chk("load_busy", 64'(cfg_busy_v), 64'd1);
      cfg_di_v = (k < int'(TOT)) ? bits[k] : 1'($urandom);
    end
    @(negedge gclk_v);
    chk("load_busy_last", 64'(cfg_busy_v), 64'd1);
    cfg_load_v = 1'b0;
    @(negedge gclk_v);
    chk("load_err", 64'(cfg_err_v), 64'(n != int'(TOT)));
    chk("load_busy_end", 64'(cfg_busy_v), 64'd0);
    @(negedge gclk_v);
    chk("load_err_clr", 64'(cfg_err_v), 64'd0);
    if (n == int'(TOT))
      for (int i = 0; i < int'(MC); i++) cfg_m[i] = bits[6*i +: 6];
    check_all("after_load");
  endtask

  logic [TOT-1:0] cv;

  initial begin
    clear_model();
    // 1: reset with all product terms high
    pt_or_v = '1;
    #1 gclr_v = 1'b1;
    #11;
    chk("rst_pad", 64'(pad_v), 64'd0);
    chk("rst_oe", 64'(oe_v), 64'd0);
    chk("rst_fb", 64'(fb_v), 64'd0);
    chk("rst_cas", 64'(cas_out_v), 64'd0);
    chk("rst_busy", 64'(cfg_busy_v), 64'd0);
    chk("rst_err", 64'(cfg_err_v), 64'd0);
    chk("rst_do", 64'(cfg_do_v), 64'd0);
    @(negedge gclk_v);
    gclr_v = 1'b0;
    pt_or_v = '0;

    // 2: cell0 registered D with output enable
    cv = '0; cv[5:0] = 6'b100001;
    load_cfg(cv, int'(TOT));
    step(16'h0001, 16'h0001, '0, '0);
    chk("tp2_pad0", 64'(pad_v[0]), 64'd1);
    chk("tp2_fb0", 64'(fb_v[0]), 64'd1);

    // 3: T mode toggling, then hold with ce low
    cv[5:0] = 6'b100011;
    load_cfg(cv, int'(TOT));
    step(16'h0000, 16'h0000, '0, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      step(16'h0001, 16'h0001, '0, '0);
      chk("tp3_toggle", 64'(pad_v[0]), 64'((k % 2) == 0));
    end
    step(16'h0001, 16'h0000, '0, '0);
    step(16'h0001, 16'h0000, '0, '0);
    chk("tp3_hold", 64'(pad_v[0]), 64'd0);

    // 4: cascade of cells 0,1 into combinational cell2, then inverted
    cv = '0; cv[5:0] = 6'b010000; cv[11:6] = 6'b010000; cv[17:12] = 6'b100000;
    load_cfg(cv, int'(TOT));
    step(16'h0001, 16'h0000, '0, '0);
    chk("tp4_pad2", 64'(pad_v[2]), 64'd1);
    chk("tp4_pad0", 64'(pad_v[0]), 64'd0);
    cv[17:12] = 6'b100100;
    load_cfg(cv, int'(TOT));
    step(16'h0001, 16'h0000, '0, '0);
    chk("tp4_inv_pad2", 64'(pad_v[2]), 64'd0);

    // 5: short load and overrun both abort and leave the configuration alone
    load_cfg({TOT{1'b1}}, int'(TOT) - 1);
    step(16'h0001, 16'h0000, '0, '0);
    chk("tp5_pad2_kept", 64'(pad_v[2]), 64'd0);
    load_cfg({TOT{1'b1}}, int'(TOT) + 3);
    step(16'h0001, 16'h0000, '0, '0);

    // 6: reset mid-shift with async set and reset both active on cell 3
    @(negedge gclk_v);
    cfg_load_v = 1'b1; cfg_di_v = 1'b1;
    repeat (5) @(negedge gclk_v);
    chk("tp6_busy_pre", 64'(cfg_busy_v), 64'd1);
    as_v = 16'h0008; ar_v = 16'h0008;
    #2 gclr_v = 1'b1;
    #1;
    chk("tp6_busy", 64'(cfg_busy_v), 64'd0);
    chk("tp6_pad", 64'(pad_v), 64'd0);
    chk("tp6_oe", 64'(oe_v), 64'd0);
    chk("tp6_fb", 64'(fb_v), 64'd0);
    chk("tp6_err", 64'(cfg_err_v), 64'd0);
    chk("tp6_do", 64'(cfg_do_v), 64'd0);
    cfg_load_v = 1'b0; as_v = '0; ar_v = '0;
    @(negedge gclk_v);
    gclr_v = 1'b0;
    clear_model();
    step(16'hFFFF, 16'hFFFF, '0, '0);
    chk("tp6_idle", 64'(cfg_busy_v), 64'd0);

    // Random configurations and traffic
    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < int'(TOT); b++) cv[b] = 1'($urandom);
      load_cfg(cv, int'(TOT));
      for (int s = 0; s < 30; s++) begin
        logic [MC-1:0] ra, rs;
        for (int i = 0; i < int'(MC); i++) begin
          ra[i] = ($urandom_range(0, 9) == 0);
          rs[i] = ($urandom_range(0, 9) == 0);
        end
        step(16'($urandom), 16'($urandom), rs, ra);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
